// File: rtl/jump_ctrl.sv
// jump_ctrl: redirect initiator for the PC of the 9-bit MIPS core; resolves relative, LUT, call and return redirects.
// Latency: a taken redirect seen in cycle T drives jump_en/flush/target in cycle T+1; the PC loads at the end of T+1.
// Backpressure: none; the PC must accept the redirect. br_valid seen during the JUMP cycle is ignored (squashed instruction).
//
// Optional feature: define JUMP_RAS_EN to build the return-address stack.
//   Without it, type 10 behaves as type 01, type 11 is never taken, and ras_ovf/ras_unf are tied 0.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   prog_ctr          address of the instruction being decoded
//   br_valid/br_type  decoded redirect and its kind (00 rel, 01 abs, 10 call, 11 return)
//   br_idx            LUT index (01/10) or signed offset (00)
//   cond_true         branch condition for type 00
//   lut_we/waddr/wdata  synchronous LUT write port
//   jump_en/target    redirect to the PC
//   flush             squash the instruction currently being fetched
//   ras_ovf/ras_unf   sticky stack overflow / underflow flags

module jump_ctrl #(
    parameter int D         = 10,
    parameter int LW        = 5,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [D-1:0]  prog_ctr,
    input  logic          br_valid,
    input  logic [1:0]    br_type,
    input  logic [LW-1:0] br_idx,
    input  logic          cond_true,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic          jump_en,
    output logic [D-1:0]  target,
    output logic          flush,
    output logic          ras_ovf,
    output logic          ras_unf
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_JUMP = 1'b1
    } state_t;

    localparam logic [1:0] BR_REL  = 2'b00;
    localparam logic [1:0] BR_ABS  = 2'b01;
    localparam logic [1:0] BR_CALL = 2'b10;
    localparam logic [1:0] BR_RET  = 2'b11;

    state_t         r_state;
    logic           r_jump_en;
    logic           r_flush;
    logic [D-1:0]   r_target;

    logic [D-1:0]   r_lut [2**LW];

    logic           w_taken;
    logic [D-1:0]   w_tgt;
    logic [D-1:0]   w_rel_tgt;
    logic [D-1:0]   w_lut_rd;

    // Offset is sign-extended and added modulo 2**D, so it wraps in both directions.
    assign w_rel_tgt = prog_ctr + {{(D-LW){br_idx[LW-1]}}, br_idx};
    // Combinational read: a same-cycle write to this index is not visible until the next cycle.
    assign w_lut_rd  = r_lut[br_idx];

    // LUT contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            r_lut[lut_waddr] <= lut_wdata;
        end
    end

`ifdef JUMP_RAS_EN
    localparam int RPW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RCW = $clog2(RAS_DEPTH + 1);

    logic [D-1:0]   r_ras_mem [RAS_DEPTH];
    logic [RPW-1:0] r_ras_sp;       // next slot to write
    logic [RCW-1:0] r_ras_cnt;      // valid entries, saturates at RAS_DEPTH
    logic           r_ras_ovf;
    logic           r_ras_unf;

    logic           w_push;
    logic           w_pop;
    logic           w_unf;
    logic           w_ras_empty;
    logic           w_ras_full;
    logic [RPW-1:0] w_sp_next;
    logic [RPW-1:0] w_sp_prev;
    logic [D-1:0]   w_ras_top;

    assign w_ras_empty = (r_ras_cnt == '0);
    assign w_ras_full  = (r_ras_cnt == RCW'(RAS_DEPTH));
    assign w_sp_next   = (r_ras_sp == RPW'(RAS_DEPTH - 1)) ? '0 : r_ras_sp + 1'b1;
    assign w_sp_prev   = (r_ras_sp == '0) ? RPW'(RAS_DEPTH - 1) : r_ras_sp - 1'b1;
    assign w_ras_top   = r_ras_mem[w_sp_prev];
`endif

    always_comb begin
        w_taken = 1'b0;
        w_tgt   = w_rel_tgt;
`ifdef JUMP_RAS_EN
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_unf   = 1'b0;
`endif
        if (r_state == S_IDLE && br_valid) begin
            case (br_type)
                BR_REL: begin
                    w_taken = cond_true;
                    w_tgt   = w_rel_tgt;
                end
                BR_ABS: begin
                    w_taken = 1'b1;
                    w_tgt   = w_lut_rd;
                end
                BR_CALL: begin
                    w_taken = 1'b1;
                    w_tgt   = w_lut_rd;
`ifdef JUMP_RAS_EN
                    w_push  = 1'b1;
`endif
                end
                BR_RET: begin
`ifdef JUMP_RAS_EN
                    if (!w_ras_empty) begin
                        w_taken = 1'b1;
                        w_tgt   = w_ras_top;
                        w_pop   = 1'b1;
                    end else begin
                        w_unf   = 1'b1;
                    end
`endif
                end
                default: begin
                    w_taken = 1'b0;
                end
            endcase
        end
    end

    // Two-state redirect FSM with registered outputs; target holds its last value in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_jump_en <= 1'b0;
            r_flush   <= 1'b0;
            r_target  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_taken) begin
                        r_state   <= S_JUMP;
                        r_jump_en <= 1'b1;
                        r_flush   <= 1'b1;
                        r_target  <= w_tgt;
                    end
                end
                S_JUMP: begin
                    r_state   <= S_IDLE;
                    r_jump_en <= 1'b0;
                    r_flush   <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_jump_en <= 1'b0;
                    r_flush   <= 1'b0;
                end
            endcase
        end
    end

`ifdef JUMP_RAS_EN
    // Stack storage carries no reset; only pointer and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras_mem[r_ras_sp] <= prog_ctr + D'(1);
        end
    end

    // Circular stack: a push onto a full stack overwrites the oldest entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ras_sp  <= '0;
            r_ras_cnt <= '0;
            r_ras_ovf <= 1'b0;
            r_ras_unf <= 1'b0;
        end else begin
            if (w_push) begin
                r_ras_sp <= w_sp_next;
                if (w_ras_full) begin
                    r_ras_ovf <= 1'b1;
                end else begin
                    r_ras_cnt <= r_ras_cnt + 1'b1;
                end
            end else if (w_pop) begin
                r_ras_sp  <= w_sp_prev;
                r_ras_cnt <= r_ras_cnt - 1'b1;
            end
            if (w_unf) begin
                r_ras_unf <= 1'b1;
            end
        end
    end

    assign ras_ovf = r_ras_ovf;
    assign ras_unf = r_ras_unf;
`else
    assign ras_ovf = 1'b0;
    assign ras_unf = 1'b0;
`endif

    assign jump_en = r_jump_en;
    assign flush   = r_flush;
    assign target  = r_target;

endmodule

// File: tb/tb_jump_ctrl.sv
// tb_jump_ctrl: directed self-checking bench for jump_ctrl.
// Latency: expects redirect outputs one cycle after the taken branch is presented.
// Backpressure: none; inputs driven on negedge, outputs sampled on negedge.

module tb_jump_ctrl;

    localparam int D  = 10;
    localparam int LW = 5;

    logic          clk;
    logic          reset;
    logic [D-1:0]  prog_ctr;
    logic          br_valid;
    logic [1:0]    br_type;
    logic [LW-1:0] br_idx;
    logic          cond_true;
    logic          lut_we;
    logic [LW-1:0] lut_waddr;
    logic [D-1:0]  lut_wdata;
    logic          jump_en;
    logic [D-1:0]  target;
    logic          flush;
    logic          ras_ovf;
    logic          ras_unf;

    int checks;
    int errors;

    jump_ctrl #(.D(D), .LW(LW), .RAS_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_ctr  (prog_ctr),
        .br_valid  (br_valid),
        .br_type   (br_type),
        .br_idx    (br_idx),
        .cond_true (cond_true),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .jump_en   (jump_en),
        .target    (target),
        .flush     (flush),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one redirect for exactly one cycle; returns at the negedge of the following cycle.
    task automatic do_branch(input logic [1:0] t, input logic [LW-1:0] idx,
                             input logic c, input logic [D-1:0] pc);
        prog_ctr  = pc;
        br_type   = t;
        br_idx    = idx;
        cond_true = c;
        br_valid  = 1'b1;
        @(negedge clk);
        br_valid  = 1'b0;
    endtask

    task automatic lut_write(input logic [LW-1:0] a, input logic [D-1:0] d);
        lut_we    = 1'b1;
        lut_waddr = a;
        lut_wdata = d;
        @(negedge clk);
        lut_we    = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL rst_jump_en got %b want 0", jump_en); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b want 0", flush); end
        checks++; if (target !== 10'h000) begin errors++; $display("FAIL rst_target got %h want 000", target); end
        checks++; if (ras_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", ras_ovf); end
        checks++; if (ras_unf !== 1'b0) begin errors++; $display("FAIL rst_unf got %b want 0", ras_unf); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL rst_release_jump got %b want 0", jump_en); end
    endtask

    task automatic test_reset_mid_jump;
        do_branch(2'b00, 5'h04, 1'b1, 10'h010);
        checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_jump got %b want 1", jump_en); end
        checks++; if (target !== 10'h014) begin errors++; $display("FAIL midrst_pre_target got %h want 014", target); end
        #2 reset = 1'b0;
        #1;
        checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL midrst_jump got %b want 0", jump_en); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL midrst_flush got %b want 0", flush); end
        checks++; if (target !== 10'h000) begin errors++; $display("FAIL midrst_target got %h want 000", target); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL midrst_after got %b want 0", jump_en); end
    endtask

    task automatic test_rel_branch;
        do_branch(2'b00, 5'h03, 1'b1, 10'h3FE);
        checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL rel_fwd_jump got %b want 1", jump_en); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rel_fwd_flush got %b want 1", flush); end
        checks++; if (target !== 10'h001) begin errors++; $display("FAIL rel_fwd_target got %h want 001", target); end
        @(negedge clk);
        checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL rel_back_idle_jump got %b want 0", jump_en); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rel_back_idle_flush got %b want 0", flush); end
        do_branch(2'b00, 5'h03, 1'b0, 10'h3FE);
        checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL rel_nottaken_jump got %b want 0", jump_en); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rel_nottaken_flush got %b want 0", flush); end
        do_branch(2'b00, 5'h1E, 1'b1, 10'h001);
        checks++; if (target !== 10'h3FF) begin errors++; $display("FAIL rel_neg_wrap_target got %h want 3ff", target); end
        @(negedge clk);
    endtask

    task automatic test_lut;
        lut_write(5'd7, 10'h155);
        do_branch(2'b01, 5'd7, 1'b0, 10'h050);
        checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL lut_jump got %b want 1", jump_en); end
        checks++; if (target !== 10'h155) begin errors++; $display("FAIL lut_target got %h want 155", target); end
        @(negedge clk);
        lut_we    = 1'b1;
        lut_waddr = 5'd7;
        lut_wdata = 10'h0AA;
        do_branch(2'b01, 5'd7, 1'b0, 10'h060);
        lut_we    = 1'b0;
        checks++; if (target !== 10'h155) begin errors++; $display("FAIL lut_rdw_old got %h want 155", target); end
        @(negedge clk);
        do_branch(2'b01, 5'd7, 1'b1, 10'h070);
        checks++; if (target !== 10'h0AA) begin errors++; $display("FAIL lut_new got %h want 0aa", target); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        do_branch(2'b01, 5'd7, 1'b0, 10'h080);
        // Branch presented during JUMP belongs to the squashed fetch.
        prog_ctr  = 10'h100;
        br_type   = 2'b00;
        br_idx    = 5'h05;
        cond_true = 1'b1;
        br_valid  = 1'b1;
        checks++; if (target !== 10'h0AA) begin errors++; $display("FAIL b2b_first_target got %h want 0aa", target); end
        @(negedge clk);
        br_valid = 1'b0;
        checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL b2b_ignored_jump got %b want 0", jump_en); end
        checks++; if (target !== 10'h0AA) begin errors++; $display("FAIL b2b_ignored_target got %h want 0aa", target); end
        do_branch(2'b00, 5'h05, 1'b1, 10'h100);
        checks++; if (target !== 10'h105) begin errors++; $display("FAIL b2b_next_target got %h want 105", target); end
        @(negedge clk);
    endtask

`ifdef JUMP_RAS_EN
    task automatic test_call_return;
        lut_write(5'd2, 10'h200);
        do_branch(2'b10, 5'd2, 1'b0, 10'h020);
        br_type  = 2'b11;
        br_valid = 1'b1;
        checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL call_jump got %b want 1", jump_en); end
        checks++; if (target !== 10'h200) begin errors++; $display("FAIL call_target got %h want 200", target); end
        @(negedge clk);
        br_valid = 1'b0;
        checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL call_ignored_ret got %b want 0", jump_en); end
        do_branch(2'b11, 5'd0, 1'b0, 10'h300);
        checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL ret_jump got %b want 1", jump_en); end
        checks++; if (target !== 10'h021) begin errors++; $display("FAIL ret_target got %h want 021", target); end
        @(negedge clk);
        checks++; if (ras_unf !== 1'b0) begin errors++; $display("FAIL ret_unf got %b want 0", ras_unf); end
    endtask

    task automatic test_ras_overflow;
        for (int i = 0; i < 5; i++) begin
            do_branch(2'b10, 5'd2, 1'b0, 10'h100 + 10'(i));
            @(negedge clk);
            checks++;
            if (ras_ovf !== ((i == 4) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL ovf_after_call%0d got %b want %b", i, ras_ovf, (i == 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_branch(2'b11, 5'd0, 1'b0, 10'h300);
            checks++;
            if (target !== 10'h105 - 10'(i)) begin
                errors++; $display("FAIL ovf_ret%0d got %h want %h", i, target, 10'h105 - 10'(i));
            end
            @(negedge clk);
        end
        do_branch(2'b11, 5'd0, 1'b0, 10'h300);
        checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL unf_jump got %b want 0", jump_en); end
        checks++; if (ras_unf !== 1'b1) begin errors++; $display("FAIL unf_flag got %b want 1", ras_unf); end
        @(negedge clk);
        checks++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ras_ovf); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ras_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ras_ovf); end
        checks++; if (ras_unf !== 1'b0) begin errors++; $display("FAIL unf_clear got %b want 0", ras_unf); end
    endtask
`else
    task automatic test_no_ras;
        lut_write(5'd2, 10'h200);
        do_branch(2'b10, 5'd2, 1'b0, 10'h020);
        checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL noras_call_jump got %b want 1", jump_en); end
        checks++; if (target !== 10'h200) begin errors++; $display("FAIL noras_call_target got %h want 200", target); end
        @(negedge clk);
        do_branch(2'b11, 5'd0, 1'b0, 10'h300);
        checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL noras_ret_jump got %b want 0", jump_en); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL noras_ret_flush got %b want 0", flush); end
        @(negedge clk);
        checks++; if (ras_ovf !== 1'b0) begin errors++; $display("FAIL noras_ovf got %b want 0", ras_ovf); end
        checks++; if (ras_unf !== 1'b0) begin errors++; $display("FAIL noras_unf got %b want 0", ras_unf); end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        prog_ctr  = '0;
        br_valid  = 1'b0;
        br_type   = 2'b00;
        br_idx    = '0;
        cond_true = 1'b0;
        lut_we    = 1'b0;
        lut_waddr = '0;
        lut_wdata = '0;
        #12;
        test_reset;
        test_reset_mid_jump;
        test_rel_branch;
        test_lut;
        test_back_to_back;
`ifdef JUMP_RAS_EN
        test_call_return;
        test_ras_overflow;
`else
        test_no_ras;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
